// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop synchronizer, start-bit glitch rejection,
// optional parity, and a single-word valid/ready output register with sticky overrun.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_last;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 done;
    logic                 bit_end;

    assign bit_end = (tick_cnt == FULL_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rx_last   <= 1'b1;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick) begin
                // NOTE: rx_last follows the line only on ticks, so a held-low break never looks like a fresh edge.
                rx_last <= rx_sync;
                case (state)
                    IDLE: begin
                        if (rx_last && !rx_sync) begin
                            state    <= START;
                            busy     <= 1'b1;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_sync) begin
                                state     <= DATA;
                                bit_cnt   <= '0;
                                par_en_q  <= parity_en;
                                par_odd_q <= parity_odd;
                                par_bad   <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            tick_cnt <= '0;
                            shift    <= {rx_sync, shift[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            tick_cnt <= '0;
                            par_bad  <= ((^shift) ^ rx_sync) != par_odd_q;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            tick_cnt <= '0;
                            stop_bad <= !rx_sync;
                            done     <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output word register: a completion either loads (possibly alongside a handshake) or is dropped as overrun.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (done) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data    <= shift;
                    parity_err <= par_bad;
                    frame_err  <= stop_bad;
                    rx_valid   <= 1'b1;
                end
            end
        end
    end

endmodule
